// File: rtl/link_pkg.sv
// Shared types and constants for the inter-node link receiver.
package link_pkg;

  localparam int unsigned LINK_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } linkState_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
module bit_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= {STAGES{RESET_VAL}};
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_link_receiver.sv
// Oversampling SPI-style frame deserialiser with valid/ready output buffer.
module spi_link_receiver
  import link_pkg::*;
#(
  parameter int unsigned WIDTH       = LINK_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_clk,
  input  logic             ser_cs,
  input  logic             ser_data,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic clkSync, csSync, dataSync;
  logic clkHist, csHist, dataHist;
  logic clkRise, csRise, csFall;

  linkState_t       state, stateNext;
  logic [CNT_W-1:0] bitCnt, bitCntNext;
  logic [WIDTH-1:0] shiftReg, shiftNext;
  logic             commit, abort;

  bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uClkSync (
    .clk(clk), .reset(reset), .d(ser_clk), .q(clkSync)
  );
  bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsSync (
    .clk(clk), .reset(reset), .d(ser_cs), .q(csSync)
  );
  bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uDataSync (
    .clk(clk), .reset(reset), .d(ser_data), .q(dataSync)
  );

  // History flops and registered edge strobes; dataHist stays aligned with
  // the clkRise strobe so the shift samples the bit that matched that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkHist  <= 1'b0;
      csHist   <= 1'b1;
      dataHist <= 1'b0;
      clkRise  <= 1'b0;
      csRise   <= 1'b0;
      csFall   <= 1'b0;
    end else begin
      clkHist  <= clkSync;
      csHist   <= csSync;
      dataHist <= dataSync;
      clkRise  <= clkSync & ~clkHist;
      csRise   <= csSync & ~csHist;
      csFall   <= ~csSync & csHist;
    end
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
    end
  end

  // Next-state, shift and commit/abort decisions.
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    commit     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (csRise) begin
          stateNext  = SHIFT;
          bitCntNext = '0;
          shiftNext  = '0;
        end
      end
      SHIFT: begin
        if (csFall) begin
          abort     = 1'b1;
          stateNext = IDLE;
        end else if (clkRise) begin
          shiftNext  = {shiftReg[WIDTH-2:0], dataHist};
          bitCntNext = bitCnt + 1'b1;
          if (bitCnt == LAST_BIT) stateNext = WAIT_END;
        end
      end
      WAIT_END: begin
        if (clkRise) begin
          abort     = 1'b1;
          stateNext = IDLE;
        end else if (csFall) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output buffer with overrun detection and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= abort;
      overrun   <= 1'b0;
      if (commit) begin
        if (!word_valid || word_ready) begin
          word_out   <= shiftReg;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_link_receiver.sv
// Directed self-checking bench for spi_link_receiver.
module tb_spi_link_receiver;
  import link_pkg::*;

  localparam int unsigned PH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serClk = 1'b0;
  logic        serCs = 1'b0;
  logic        serData = 1'b0;
  logic [31:0] wordOut;
  logic        wordValid;
  logic        wordReady = 1'b0;
  logic        frameErr;
  logic        overrun;

  int unsigned nChecks = 0;
  int unsigned nPass = 0;
  int unsigned errCnt = 0;
  int unsigned ovrCnt = 0;
  int unsigned errBase, ovrBase;

  spi_link_receiver #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ser_clk(serClk), .ser_cs(serCs),
    .ser_data(serData), .word_out(wordOut), .word_valid(wordValid),
    .word_ready(wordReady), .frame_err(frameErr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle status outputs.
  always @(posedge clk) begin
    if (frameErr) errCnt++;
    if (overrun)  ovrCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic waitClk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    serClk = 1'b0;
    serCs  = 1'b1;
    waitClk(PH);
  endtask

  task automatic clockBits(input logic [31:0] data, input int unsigned n);
    logic b;
    for (int i = int'(n) - 1; i >= 0; i--) begin
      b = (i < 32) ? data[i] : 1'b0;
      serData = b;
      waitClk(PH);
      serClk = 1'b1;
      waitClk(PH);
      serClk = 1'b0;
    end
    waitClk(PH);
  endtask

  task automatic endFrame();
    serCs = 1'b0;
    waitClk(8);
  endtask

  task automatic sendFrame(input logic [31:0] data);
    startFrame();
    clockBits(data, 32);
    endFrame();
  endtask

  task automatic pulseReady();
    wordReady = 1'b1;
    waitClk(1);
    wordReady = 1'b0;
  endtask

  initial begin
    // Reset state
    waitClk(3);
    check("rst_word", wordOut, 32'h0);
    check("rst_valid", {31'b0, wordValid}, 32'h0);
    check("rst_err", {31'b0, frameErr}, 32'h0);
    check("rst_ovr", {31'b0, overrun}, 32'h0);
    reset = 1'b0;
    waitClk(4);

    // Basic frame with latency check
    errBase = errCnt; ovrBase = ovrCnt;
    startFrame();
    clockBits(32'hDEADBEEF, 32);
    serCs = 1'b0;
    waitClk(3);
    check("lat3_valid", {31'b0, wordValid}, 32'h0);
    waitClk(1);
    check("lat4_valid", {31'b0, wordValid}, 32'h1);
    check("beef_word", wordOut, 32'hDEADBEEF);
    waitClk(4);
    check("beef_noerr", errCnt - errBase, 32'h0);
    check("beef_noovr", ovrCnt - ovrBase, 32'h0);
    pulseReady();
    check("beef_consumed", {31'b0, wordValid}, 32'h0);

    // Short frame: 31 clocks
    errBase = errCnt;
    startFrame();
    clockBits(32'h7FFFFFFF, 31);
    endFrame();
    check("short_err", errCnt - errBase, 32'h1);
    check("short_valid", {31'b0, wordValid}, 32'h0);
    sendFrame(32'h00000001);
    check("one_word", wordOut, 32'h00000001);
    check("one_valid", {31'b0, wordValid}, 32'h1);
    pulseReady();

    // Long frame: 33 clocks, error on the 33rd edge before cs falls
    errBase = errCnt;
    startFrame();
    clockBits(32'hCAFEF00D, 33);
    check("long_err", errCnt - errBase, 32'h1);
    endFrame();
    check("long_err_once", errCnt - errBase, 32'h1);
    check("long_valid", {31'b0, wordValid}, 32'h0);
    check("long_word", wordOut, 32'h00000001);

    // Two frames without consumption -> overrun
    ovrBase = ovrCnt;
    sendFrame(32'h11111111);
    sendFrame(32'h22222222);
    check("ovr_word", wordOut, 32'h11111111);
    check("ovr_cnt", ovrCnt - ovrBase, 32'h1);
    check("ovr_valid", {31'b0, wordValid}, 32'h1);
    pulseReady();

    // Ready exactly in the second commit cycle -> replaced, no overrun
    ovrBase = ovrCnt;
    sendFrame(32'h11111111);
    startFrame();
    clockBits(32'h22222222, 32);
    serCs = 1'b0;
    waitClk(3);
    wordReady = 1'b1;
    waitClk(1);
    wordReady = 1'b0;
    waitClk(4);
    check("rdy_word", wordOut, 32'h22222222);
    check("rdy_valid", {31'b0, wordValid}, 32'h1);
    check("rdy_noovr", ovrCnt - ovrBase, 32'h0);
    pulseReady();

    // Frame in flight at reset release is ignored
    reset = 1'b1;
    startFrame();
    clockBits(32'hFFC00000, 10);
    errBase = errCnt;
    reset = 1'b0;
    clockBits(32'h003FFFFF, 22);
    endFrame();
    check("inflt_err", errCnt - errBase, 32'h0);
    check("inflt_valid", {31'b0, wordValid}, 32'h0);
    sendFrame(32'hA5A5A5A5);
    check("a5_word", wordOut, 32'hA5A5A5A5);
    check("a5_valid", {31'b0, wordValid}, 32'h1);

    // Asynchronous reset mid-SHIFT while a word is held
    startFrame();
    clockBits(32'hF0000000, 5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_word", wordOut, 32'h0);
    check("arst_valid", {31'b0, wordValid}, 32'h0);
    check("arst_err", {31'b0, frameErr}, 32'h0);
    check("arst_ovr", {31'b0, overrun}, 32'h0);
    check("arst_state", {30'b0, dut.state}, {30'b0, IDLE});
    serCs = 1'b0;
    waitClk(4);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
